// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared widths, mode codes, frame-length helper and FSM states
//               for the FFT frame sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int unsigned c_dw = 34;

    localparam logic [1:0] c_mode_16  = 2'b00;
    localparam logic [1:0] c_mode_32  = 2'b01;
    localparam logic [1:0] c_mode_64  = 2'b10;
    localparam logic [1:0] c_mode_128 = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Points per frame: 16 << mode.
    function automatic logic [7:0] frame_len(input logic [1:0] mode);
        logic [7:0] len;
        case (mode)
            c_mode_16:  len = 8'd16;
            c_mode_32:  len = 8'd32;
            c_mode_64:  len = 8'd64;
            c_mode_128: len = 8'd128;
            default:    len = 8'd16;
        endcase
        return len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_beat_counter.sv
`default_nettype none
// ============================================================================
// Module      : fft_beat_counter
// Description : Loadable up-counter that wraps to zero after reaching term,
//               with synchronous clear and terminal-count flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_beat_counter #(
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             en,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_count <= '0;
        end else if (ld) begin
            r_count <= ld_val;
        end else if (en) begin
            r_count <= (r_count == term) ? '0 : r_count + 1'b1;
        end
    end

    assign count = r_count;
    assign tc    = (r_count == term);

endmodule
`default_nettype wire

// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_ctrl
// Description : Frames a host sample stream into the FFT core, tracks the
//               core's fixed latency and re-emits the results with valid/last.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int DW      = c_dw,
    parameter int LATENCY = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [1:0]    req_mode,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          core_start,
    output logic [1:0]    core_mode,
    output logic [DW-1:0] core_din,
    input  logic [DW-1:0] core_dout,
    input  logic [1:0]    core_dout_mode,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    output logic [1:0]    m_mode,
    output logic          m_last,
    output logic          busy,
    output logic          err_underrun
);

    localparam int              c_lat_w    = $clog2(LATENCY + 1);
    localparam logic [c_lat_w-1:0] c_lat_term = c_lat_w'(LATENCY - 1);

    state_t              r_state;
    state_t              w_state_d;
    logic                r_req_ready;
    logic                r_s_ready;
    logic                r_core_start;
    logic [1:0]          r_core_mode;
    logic [DW-1:0]       r_core_din;
    logic                r_m_valid;
    logic [DW-1:0]       r_m_data;
    logic [1:0]          r_m_mode;
    logic                r_m_last;
    logic                r_busy;
    logic                r_err_underrun;

    logic                w_req_fire;
    logic                w_s_fire;
    logic                w_underrun;
    logic [6:0]          w_beat_term;
    logic [6:0]          w_beat_cnt;
    logic                w_beat_tc;
    logic [c_lat_w-1:0]  w_lat_cnt;
    logic                w_lat_tc;
    logic                w_lat_cnt_unused;

    assign w_req_fire  = req_valid && r_req_ready;
    assign w_s_fire    = s_valid && r_s_ready;
    assign w_beat_term = 7'(frame_len(r_core_mode) - 8'd1);
    // Once beat 0 is in, the count is non-zero until the frame leaves LOAD.
    assign w_underrun  = (r_state == LOAD) && (w_beat_cnt != 7'd0) && !s_valid;
    assign w_lat_cnt_unused = ^w_lat_cnt;

    fft_beat_counter #(
        .WIDTH (7)
    ) u_beat_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_underrun || (r_state == IDLE)),
        .ld     (1'b0),
        .ld_val (7'd0),
        .en     (w_s_fire || (r_state == OUT)),
        .term   (w_beat_term),
        .count  (w_beat_cnt),
        .tc     (w_beat_tc)
    );

    fft_beat_counter #(
        .WIDTH (c_lat_w)
    ) u_lat_cnt (
        .clk    (clk),
        .rst    (rst),
        .clr    (r_state != WAIT),
        .ld     (1'b0),
        .ld_val ('0),
        .en     (r_state == WAIT),
        .term   (c_lat_term),
        .count  (w_lat_cnt),
        .tc     (w_lat_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE: if (w_req_fire) w_state_d = LOAD;
            LOAD: begin
                if (w_underrun) begin
                    w_state_d = IDLE;
                end else if (w_s_fire && w_beat_tc) begin
                    w_state_d = WAIT;
                end
            end
            WAIT: if (w_lat_tc) w_state_d = OUT;
            OUT:  if (w_beat_tc) w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // req_ready and busy trail IDLE entry by one cycle so a new request is
    // never accepted in the same cycle the previous frame finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_ready    <= 1'b0;
            r_s_ready      <= 1'b0;
            r_core_start   <= 1'b0;
            r_core_mode    <= 2'b00;
            r_core_din     <= '0;
            r_m_valid      <= 1'b0;
            r_m_data       <= '0;
            r_m_mode       <= 2'b00;
            r_m_last       <= 1'b0;
            r_busy         <= 1'b0;
            r_err_underrun <= 1'b0;
        end else begin
            r_req_ready    <= (r_state == IDLE) && (w_state_d == IDLE);
            r_s_ready      <= (w_state_d == LOAD);
            r_busy         <= (r_state != IDLE) || (w_state_d != IDLE);
            r_core_start   <= w_s_fire && (w_beat_cnt == 7'd0);
            r_err_underrun <= w_underrun;
            r_m_valid      <= (r_state == OUT);
            r_m_last       <= (r_state == OUT) && w_beat_tc;
            if (w_req_fire) begin
                r_core_mode <= req_mode;
            end
            if (w_s_fire) begin
                r_core_din <= s_data;
            end
            if (r_state == OUT) begin
                r_m_data <= core_dout;
                r_m_mode <= core_dout_mode;
            end
        end
    end

    assign req_ready    = r_req_ready;
    assign s_ready      = r_s_ready;
    assign core_start   = r_core_start;
    assign core_mode    = r_core_mode;
    assign core_din     = r_core_din;
    assign m_valid      = r_m_valid;
    assign m_data       = r_m_data;
    assign m_mode       = r_m_mode;
    assign m_last       = r_m_last;
    assign busy         = r_busy;
    assign err_underrun = r_err_underrun;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_ctrl
// Description : Directed self-checking bench for fft_frame_ctrl with a
//               behavioural fixed-latency core.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_ctrl;

    localparam int DW  = 34;
    localparam int LAT = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_mode = 2'b00;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          core_start;
    logic [1:0]    core_mode;
    logic [DW-1:0] core_din;
    logic [DW-1:0] core_dout;
    logic [1:0]    core_dout_mode;
    logic          m_valid;
    logic [DW-1:0] m_data;
    logic [1:0]    m_mode;
    logic          m_last;
    logic          busy;
    logic          err_underrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_mlast_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_frame_ctrl #(
        .DW      (DW),
        .LATENCY (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_mode       (req_mode),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_data         (s_data),
        .core_start     (core_start),
        .core_mode      (core_mode),
        .core_din       (core_din),
        .core_dout      (core_dout),
        .core_dout_mode (core_dout_mode),
        .m_valid        (m_valid),
        .m_data         (m_data),
        .m_mode         (m_mode),
        .m_last         (m_last),
        .busy           (busy),
        .err_underrun   (err_underrun)
    );

    // Core model: output k appears LAT cycles after sample N-1 sat on core_din.
    logic [DW-1:0] hist [0:159];
    int            core_tap;
    always @(posedge clk) begin
        hist[0] <= core_din;
        for (int i = 1; i < 160; i++) hist[i] <= hist[i-1];
    end
    always_comb core_tap = LAT + (16 << core_mode) - 2;
    assign core_dout      = hist[core_tap];
    assign core_dout_mode = core_mode;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "/req_ready"},    req_ready,    0);
        check_val({tag, "/s_ready"},      s_ready,      0);
        check_val({tag, "/core_start"},   core_start,   0);
        check_val({tag, "/core_mode"},    core_mode,    0);
        check_val({tag, "/core_din"},     core_din,     0);
        check_val({tag, "/m_valid"},      m_valid,      0);
        check_val({tag, "/m_data"},       m_data,       0);
        check_val({tag, "/m_mode"},       m_mode,       0);
        check_val({tag, "/m_last"},       m_last,       0);
        check_val({tag, "/busy"},         busy,         0);
        check_val({tag, "/err_underrun"}, err_underrun, 0);
    endtask

    // Entered and left at a falling edge.
    task automatic apply_reset(input string tag);
        rst = 1'b1; req_valid = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        check_reset_outputs({tag, "_e1"});
        @(negedge clk);
        check_reset_outputs({tag, "_e2"});
        rst = 1'b0;
        @(negedge clk);
        check_val({tag, "/req_ready_release"}, req_ready, 1);
        check_val({tag, "/busy_release"}, busy, 0);
    endtask

    task automatic do_frame(input logic [1:0] mode, input logic [DW-1:0] base,
                            input int pre_gap, input int gap_beat,
                            input int rst_in_beat, input int rst_out_beat,
                            input bit hold, input logic [1:0] hold_mode,
                            input int exp_req_cyc);
        int   n, guard, hs, idx, t_l, nerr, nv;
        logic exp_v;
        n = 16 << mode;
        req_valid = 1'b1; req_mode = mode;
        guard = 0;
        while (!req_ready && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check_val("req_accept", req_ready, 1);
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        if (exp_req_cyc >= 0) check_val("req_accept_cycle", cyc, exp_req_cyc);
        @(negedge clk);
        req_valid = hold;
        req_mode  = hold ? hold_mode : 2'b00;
        check_val("req_ready_low", req_ready, 0);
        check_val("s_ready_high", s_ready, 1);
        check_val("busy_load", busy, 1);
        check_val("core_mode", core_mode, mode);
        for (int g = 0; g < pre_gap; g++) begin
            s_valid = 1'b0;
            @(negedge clk);
            check_val("pregap_s_ready", s_ready, 1);
            check_val("pregap_no_err", err_underrun, 0);
        end
        hs = 0;
        for (int k = 0; k < n; k++) begin
            if (k == rst_in_beat) begin
                apply_reset("rst_load");
                return;
            end
            if (k == gap_beat) begin
                s_valid = 1'b0;
                @(negedge clk);
                check_val("underrun_pulse", err_underrun, 1);
                check_val("underrun_req_ready_wait", req_ready, 0);
                @(negedge clk);
                check_val("underrun_pulse_end", err_underrun, 0);
                check_val("underrun_req_ready", req_ready, 1);
                check_val("underrun_busy", busy, 0);
                nv = 0; nerr = 0;
                for (int c = 0; c < LAT + n + 4; c++) begin
                    @(negedge clk);
                    if (m_valid) nv++;
                    if (err_underrun) nerr++;
                end
                check_val("underrun_no_output", nv, 0);
                check_val("underrun_single_pulse", nerr, 0);
                return;
            end
            s_valid = 1'b1;
            s_data  = base + DW'(k + 1);
            if (s_ready) hs++;
            @(negedge clk);
            check_val("core_din", core_din, base + DW'(k + 1));
            check_val("core_start", core_start, (k == 0));
        end
        s_valid = 1'b0;
        t_l = cyc;
        check_val("s_ready_low_tl", s_ready, 0);
        check_val("s_handshakes", hs, n);
        check_val("core_mode_held", core_mode, mode);
        idx = 0;
        for (int c = 0; c <= LAT + n + 1; c++) begin
            exp_v = (c >= LAT + 1) && (c <= LAT + n);
            check_val("m_valid", m_valid, exp_v);
            if (m_valid) begin
                check_val("m_data", m_data, base + DW'(idx + 1));
                check_val("m_mode", m_mode, mode);
                check_val("m_last", m_last, (idx == n - 1));
                if (m_last) last_mlast_cyc = cyc;
                if (idx == rst_out_beat) begin
                    apply_reset("rst_out");
                    return;
                end
                idx++;
            end else begin
                check_val("m_last_idle", m_last, 0);
            end
            check_val("busy", busy, (c <= LAT + n));
            check_val("req_ready", req_ready, (c == LAT + n + 1));
            if (c < LAT + n + 1) @(negedge clk);
        end
        check_val("m_valid_count", idx, n);
        check_val("t_l_offset", last_mlast_cyc - t_l, LAT + n);
    endtask

    initial begin
        @(negedge clk);
        apply_reset("rst_init");
        do_frame(2'b00, 34'h0,         0, -1, -1, -1, 1'b0, 2'b00, -1);
        do_frame(2'b11, 34'h3_0000_0000, 2, -1, -1, -1, 1'b0, 2'b00, -1);
        do_frame(2'b01, 34'h1_0000_0100, 0, 10, -1, -1, 1'b0, 2'b00, -1);
        do_frame(2'b01, 34'h0_0000_0200, 0, -1,  7, -1, 1'b0, 2'b00, -1);
        do_frame(2'b00, 34'h2_0000_0300, 0, -1, -1,  5, 1'b0, 2'b00, -1);
        do_frame(2'b00, 34'h0_0ABC_0000, 0, -1, -1, -1, 1'b0, 2'b00, -1);
        do_frame(2'b00, 34'h1_2345_0000, 0, -1, -1, -1, 1'b1, 2'b10, -1);
        do_frame(2'b10, 34'h2_5555_0000, 0, -1, -1, -1, 1'b0, 2'b00, last_mlast_cyc + 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
